// File: rtl/shared_affine_serial.sv
`default_nettype none
// ============================================================================
// Module   : shared_affine_serial
// Brief    : Nibble-serial masked affine layer; one 4x4 map applied share-wise.
// Revision : 1.0
// ============================================================================
module shared_affine_serial #(
  parameter int          SHARES  = 3,
  parameter int          NIBBLES = 16,
  parameter logic [15:0] MAT     = 16'h8421,
  parameter logic [3:0]  CONST   = 4'h0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SHARES*4*NIBBLES-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SHARES*4*NIBBLES-1:0] out_data,
  output logic                        busy
);

  localparam int c_SHARE_W = 4 * NIBBLES;
  localparam int c_STATE_W = SHARES * c_SHARE_W;
  localparam int c_CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     r_fsm;
  logic [c_CNT_W-1:0]         r_cnt;
  logic [c_STATE_W-1:0]       r_data;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic                       r_busy;
  logic [c_STATE_W-1:0]       w_next;
  logic [SHARES-1:0][3:0]     w_mapped;
  int unsigned                w_base;

  // Row i of MAT selects the input bits that parity into output bit i.
  function automatic logic [3:0] f_map(input logic [3:0] x, input logic add_c);
    logic [3:0] y;
    for (int i = 0; i < 4; i++) begin
      y[i] = ^(MAT[4*i +: 4] & x);
    end
    return add_c ? (y ^ CONST) : y;
  endfunction

  assign w_base = 32'({r_cnt, 2'b00});

  // Each share sees only its own nibble, keeping the shares non-complete.
  for (genvar s = 0; s < SHARES; s++) begin : g_share
    assign w_mapped[s] = f_map(r_data[s*c_SHARE_W + w_base +: 4], (s == 0));
  end

  always_comb begin
    w_next = r_data;
    for (int s = 0; s < SHARES; s++) begin
      w_next[s*c_SHARE_W + w_base +: 4] = w_mapped[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_cnt       <= '0;
      r_data      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_data     <= in_data;
            r_cnt      <= '0;
            r_fsm      <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_data <= w_next;
          if (r_cnt == c_LAST) begin
            r_cnt       <= '0;
            r_fsm       <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_fsm       <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_fsm <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_shared_affine_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_affine_serial
// Brief    : Directed self-checking bench for shared_affine_serial.
// Revision : 1.0
// ============================================================================
module tb_shared_affine_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [191:0] a_in_data, a_out_data;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [31:0]  b_in_data, b_out_data;
  logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [7:0]   c_in_data, c_out_data;

  int n_vec = 0;
  int n_err = 0;

  shared_affine_serial #(.SHARES(3), .NIBBLES(16), .MAT(16'h8421), .CONST(4'hA)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy));

  shared_affine_serial #(.SHARES(2), .NIBBLES(4), .MAT(16'hFFFF), .CONST(4'h0)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy));

  shared_affine_serial #(.SHARES(2), .NIBBLES(1), .MAT(16'h3521), .CONST(4'h5)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .busy(c_busy));

  localparam logic [191:0] c_V1  = {64'h0, 64'h1111111111111111, 64'h0123456789ABCDEF};
  localparam logic [191:0] c_E1  = {64'h0, 64'h1111111111111111, 64'hAB89EFCD23016745};
  localparam logic [191:0] c_V2  = {64'h5555555555555555, 64'h0, 64'hFEDCBA9876543210};
  localparam logic [191:0] c_E2  = {64'h5555555555555555, 64'h0, 64'h54761032DCFE98BA};
  localparam logic [191:0] c_V3  = {64'h0, 64'hDEADBEEFCAFEF00D, 64'h0};
  localparam logic [191:0] c_E3  = {64'h0, 64'hDEADBEEFCAFEF00D, 64'hAAAAAAAAAAAAAAAA};

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(output int n);
    n = 0;
    while (a_out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic run_c(input string tag, input logic [7:0] d, input logic [7:0] e);
    int n;
    c_in_data  = d;
    c_in_valid = 1'b1;
    step();
    c_in_valid = 1'b0;
    n = 0;
    while (c_out_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 192'(n), 192'(1));
    chk({tag, "_data"}, 192'(c_out_data), 192'(e));
    step();
  endtask

  initial begin
    int n;
    logic seen;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", 192'(a_in_ready), 192'(1));
    chk("rst_out_valid", 192'(a_out_valid), 192'(0));
    chk("rst_busy", 192'(a_busy), 192'(0));
    chk("rst_out_data", a_out_data, 192'(0));
    rst = 1'b0;

    // Basic transform, latency, then backpressure in DONE.
    a_in_data  = c_V1;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    chk("run_busy", 192'(a_busy), 192'(1));
    chk("run_in_ready", 192'(a_in_ready), 192'(0));
    wait_a(n);
    chk("v1_latency", 192'(n), 192'(16));
    chk("v1_data", a_out_data, c_E1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", 192'(a_out_valid), 192'(1));
      chk("bp_data", a_out_data, c_E1);
      chk("bp_in_ready", 192'(a_in_ready), 192'(0));
    end
    a_out_ready = 1'b1;
    step();
    chk("release_valid", 192'(a_out_valid), 192'(0));
    chk("release_in_ready", 192'(a_in_ready), 192'(1));
    chk("release_busy", 192'(a_busy), 192'(0));

    // in_valid held high: data changed mid-RUN must not be captured.
    a_in_data  = c_V2;
    a_in_valid = 1'b1;
    step();
    a_in_data = c_V3;
    wait_a(n);
    chk("v2_latency", 192'(n), 192'(16));
    chk("v2_data", a_out_data, c_E2);
    step();
    chk("ii_idle_in_ready", 192'(a_in_ready), 192'(1));
    chk("ii_idle_busy", 192'(a_busy), 192'(0));
    step();
    a_in_valid = 1'b0;
    chk("ii_accept_busy", 192'(a_busy), 192'(1));
    wait_a(n);
    chk("v3_latency", 192'(n), 192'(16));
    chk("v3_data", a_out_data, c_E3);
    step();

    // Reset in the middle of RUN.
    a_in_data  = c_V1;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 192'(a_out_valid), 192'(0));
    chk("midrst_in_ready", 192'(a_in_ready), 192'(1));
    chk("midrst_busy", 192'(a_busy), 192'(0));
    chk("midrst_data", a_out_data, 192'(0));
    seen = 1'b0;
    repeat (20) begin
      step();
      if (a_out_valid === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_pulse", 192'(seen), 192'(0));

    // Reset wins over a simultaneous in_valid.
    rst        = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = c_V2;
    step();
    rst        = 1'b0;
    a_in_valid = 1'b0;
    chk("rst_vs_valid_busy", 192'(a_busy), 192'(0));
    chk("rst_vs_valid_data", a_out_data, 192'(0));
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    wait_a(n);
    chk("post_rst_data", a_out_data, c_E2);
    step();

    // Reset while holding a result in DONE.
    a_in_data   = c_V3;
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    step();
    a_in_valid = 1'b0;
    wait_a(n);
    chk("done_hold_data", a_out_data, c_E3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_out_ready = 1'b1;
    chk("done_rst_valid", 192'(a_out_valid), 192'(0));
    chk("done_rst_data", a_out_data, 192'(0));

    // Parity matrix: 7 -> F, 3 -> 0; share 2 all odd-weight nibbles.
    b_in_data  = {16'h1248, 16'h3737};
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    n = 0;
    while (b_out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("b_latency", 192'(n), 192'(4));
    chk("b_data", 192'(b_out_data), 192'({16'hFFFF, 16'h0F0F}));
    step();

    // Single-nibble instance with an asymmetric matrix and constant.
    run_c("c_v1", 8'h6B, 8'hE2);
    run_c("c_v2", 8'h0F, 8'h06);
    run_c("c_v3", 8'h80, 8'h05);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
